// File: rtl/load_store_unit.sv
// Load/store front end for the byte-addressed 16-bit memory: one request at a time,
// with a watchdog on the memory wait. Define MISALIGN_TRAP_EN to trap odd word addresses.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic        ReqWord,
  input  logic        ReqSigned,
  input  logic [15:0] ReqAddress,
  input  logic [15:0] ReqData,
  output logic        RespValid,
  output logic [15:0] RespData,
  output logic        RespError,
  output logic        MemReadEnable,
  output logic        MemWriteEnable,
  output logic        MemDataWidth,
  output logic [15:0] MemAddress,
  output logic [15:0] MemDataOut,
  input  logic [15:0] MemDataIn,
  input  logic        MemReadReady,
  input  logic        MemWriteReady
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TimeoutLast = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e r_state, w_state_next;

  logic          r_req_ready, r_resp_valid, r_resp_error;
  logic          r_mem_re, r_mem_we, r_mem_width, r_write, r_signed;
  logic [15:0]   r_resp_data, r_mem_addr, r_mem_dout;
  logic [CW-1:0] r_count;

  logic          w_req_ready_d, w_resp_valid_d, w_resp_error_d;
  logic          w_mem_re_d, w_mem_we_d, w_mem_width_d, w_write_d, w_signed_d;
  logic [15:0]   w_resp_data_d, w_mem_addr_d, w_mem_dout_d;
  logic [CW-1:0] w_count_d;

  logic          w_accept, w_misalign, w_mem_done, w_timeout;
  logic [15:0]   w_load_data;

  assign w_accept = (r_state == StIdle) && ReqValid;

`ifdef MISALIGN_TRAP_EN
  assign w_misalign = ReqWord && ReqAddress[0];
`else
  assign w_misalign = 1'b0;
`endif

  // Only the ready matching the captured direction completes the access.
  assign w_mem_done  = r_write ? MemWriteReady : MemReadReady;
  assign w_timeout   = (TIMEOUT != 0) && (r_count == TimeoutLast);
  assign w_load_data = r_mem_width ? MemDataIn
                                   : {(r_signed ? {8{MemDataIn[7]}} : 8'h00), MemDataIn[7:0]};

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_next = w_misalign ? StResp : StIssue;
      StIssue: w_state_next = StWait;
      StWait:  if (w_mem_done || w_timeout) w_state_next = StResp;
      StResp:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Next values for the registered outputs; a ready beats a simultaneous timeout.
  always_comb begin
    w_req_ready_d  = (w_state_next == StIdle);
    w_resp_valid_d = (w_state_next == StResp);
    w_resp_error_d = 1'b0;
    w_resp_data_d  = '0;
    w_mem_re_d     = 1'b0;
    w_mem_we_d     = 1'b0;
    w_mem_width_d  = r_mem_width;
    w_mem_addr_d   = r_mem_addr;
    w_mem_dout_d   = r_mem_dout;
    w_write_d      = r_write;
    w_signed_d     = r_signed;
    w_count_d      = r_count;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_write_d      = ReqWrite;
          w_signed_d     = ReqSigned;
          w_mem_width_d  = ReqWord;
          w_mem_addr_d   = ReqAddress;
          w_mem_dout_d   = ReqData;
          w_mem_re_d     = !w_misalign && !ReqWrite;
          w_mem_we_d     = !w_misalign && ReqWrite;
          w_resp_error_d = w_misalign;
        end
      end
      StIssue: w_count_d = '0;
      StWait: begin
        if (w_mem_done) begin
          w_resp_data_d = r_write ? 16'h0000 : w_load_data;
        end else if (w_timeout) begin
          w_resp_error_d = 1'b1;
        end else begin
          w_count_d = r_count + CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_error <= 1'b0;
      r_resp_data  <= '0;
      r_mem_re     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_width  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_dout   <= '0;
      r_write      <= 1'b0;
      r_signed     <= 1'b0;
      r_count      <= '0;
    end else begin
      r_req_ready  <= w_req_ready_d;
      r_resp_valid <= w_resp_valid_d;
      r_resp_error <= w_resp_error_d;
      r_resp_data  <= w_resp_data_d;
      r_mem_re     <= w_mem_re_d;
      r_mem_we     <= w_mem_we_d;
      r_mem_width  <= w_mem_width_d;
      r_mem_addr   <= w_mem_addr_d;
      r_mem_dout   <= w_mem_dout_d;
      r_write      <= w_write_d;
      r_signed     <= w_signed_d;
      r_count      <= w_count_d;
    end
  end

  assign ReqReady       = r_req_ready;
  assign RespValid      = r_resp_valid;
  assign RespError      = r_resp_error;
  assign RespData       = r_resp_data;
  assign MemReadEnable  = r_mem_re;
  assign MemWriteEnable = r_mem_we;
  assign MemDataWidth   = r_mem_width;
  assign MemAddress     = r_mem_addr;
  assign MemDataOut     = r_mem_dout;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a little-endian byte memory model of
// programmable delay; honours MISALIGN_TRAP_EN for the odd-address case.
module tb_load_store_unit;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        ReqValid = 1'b0, ReqWrite = 1'b0, ReqWord = 1'b0, ReqSigned = 1'b0;
  logic [15:0] ReqAddress = '0, ReqData = '0;
  logic        ReqReady, RespValid, RespError;
  logic [15:0] RespData;
  logic        MemReadEnable, MemWriteEnable, MemDataWidth;
  logic [15:0] MemAddress, MemDataOut;
  logic [15:0] mem_dout = '0;
  logic        mem_rr = 1'b0, mem_wr = 1'b0, force_rr = 1'b0;

  load_store_unit #(.TIMEOUT(8)) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .ReqValid      (ReqValid),
    .ReqReady      (ReqReady),
    .ReqWrite      (ReqWrite),
    .ReqWord       (ReqWord),
    .ReqSigned     (ReqSigned),
    .ReqAddress    (ReqAddress),
    .ReqData       (ReqData),
    .RespValid     (RespValid),
    .RespData      (RespData),
    .RespError     (RespError),
    .MemReadEnable (MemReadEnable),
    .MemWriteEnable(MemWriteEnable),
    .MemDataWidth  (MemDataWidth),
    .MemAddress    (MemAddress),
    .MemDataOut    (MemDataOut),
    .MemDataIn     (mem_dout),
    .MemReadReady  (mem_rr | force_rr),
    .MemWriteReady (mem_wr)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  // Memory model: ready arrives mem_delay+1 cycles after the enable cycle.
  logic [7:0]  mem [0:65535];
  int          mem_delay = 2;
  bit          mem_stall = 1'b0;
  bit          busy = 1'b0;
  int          cnt = 0;
  logic [15:0] m_addr, m_wdata;
  logic        m_word, m_write;

  always @(posedge Clock) begin
    mem_rr <= 1'b0;
    mem_wr <= 1'b0;
    if (Reset) begin
      busy = 1'b0;
    end else begin
      if (MemReadEnable || MemWriteEnable) begin
        busy = 1'b1; cnt = mem_delay;
        m_addr = MemAddress; m_wdata = MemDataOut;
        m_word = MemDataWidth; m_write = MemWriteEnable;
      end else if (busy && cnt > 0) begin
        cnt = cnt - 1;
      end
      if (busy && cnt == 0 && !mem_stall) begin
        busy = 1'b0;
        if (m_write) begin
          mem[m_addr] = m_wdata[7:0];
          if (m_word) mem[16'(m_addr + 16'd1)] = m_wdata[15:8];
          mem_wr <= 1'b1;
        end else begin
          mem_dout <= m_word ? {mem[16'(m_addr + 16'd1)], mem[m_addr]} : {8'h00, mem[m_addr]};
          mem_rr   <= 1'b1;
        end
      end
    end
  end

  int en_count = 0, resp_count = 0, last_en_cyc = 0;
  always @(negedge Clock) begin
    if (MemReadEnable || MemWriteEnable) begin
      en_count    <= en_count + 1;
      last_en_cyc <= cyc;
    end
    if (RespValid) resp_count <= resp_count + 1;
  end

  int errors = 0, checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_req_ready"}, 32'(ReqReady), 1);
    check({pfx, "_resp_valid"}, 32'(RespValid), 0);
    check({pfx, "_resp_error"}, 32'(RespError), 0);
    check({pfx, "_resp_data"}, 32'(RespData), 0);
    check({pfx, "_mem_re"}, 32'(MemReadEnable), 0);
    check({pfx, "_mem_we"}, 32'(MemWriteEnable), 0);
    check({pfx, "_mem_width"}, 32'(MemDataWidth), 0);
    check({pfx, "_mem_addr"}, 32'(MemAddress), 0);
    check({pfx, "_mem_dout"}, 32'(MemDataOut), 0);
  endtask

  // lat and en_lat are relative to the accept cycle N; lat = -1 if no response came.
  task automatic do_req(input logic w, input logic word, input logic sgn,
                        input logic [15:0] addr, input logic [15:0] data,
                        output logic [15:0] rdata, output logic rerr,
                        output int lat, output int en_lat, output int n_en);
    int n, en0, t;
    en0 = en_count;
    @(negedge Clock);
    ReqValid = 1'b1; ReqWrite = w; ReqWord = word; ReqSigned = sgn;
    ReqAddress = addr; ReqData = data;
    t = 0;
    while (!ReqReady && t < 20) begin @(negedge Clock); t++; end
    n = cyc;
    @(negedge Clock);
    ReqValid = 1'b0;
    t = 0;
    while (!RespValid && t < 40) begin @(negedge Clock); t++; end
    rdata  = RespData;
    rerr   = RespError;
    lat    = RespValid ? cyc - n : -1;
    en_lat = last_en_cyc - n;
    n_en   = en_count - en0;
    @(negedge Clock);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [15:0] rd;
    logic        re;
    int          lat, enl, nen, n, r0, e0, na;
    int          acc [0:3];
    logic        rdy [0:11];

    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[3] = 8'h34;
    mem[4] = 8'h12;

    repeat (3) @(negedge Clock);
    check_reset_outputs("reset");
    Reset = 1'b0;
    @(negedge Clock);

    // Word store then loads, memory delay 2.
    mem_delay = 2;
    do_req(1'b1, 1'b1, 1'b0, 16'h0010, 16'hBEEF, rd, re, lat, enl, nen);
    check("st_lat", 32'(lat), 5);
    check("st_en_lat", 32'(enl), 1);
    check("st_n_en", 32'(nen), 1);
    check("st_err", 32'(re), 0);
    check("st_data", 32'(rd), 0);
    check("st_mem", {16'h0, mem[17], mem[16]}, 32'h0000BEEF);

    do_req(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0, rd, re, lat, enl, nen);
    check("ldw_data", 32'(rd), 32'hBEEF);
    check("ldw_lat", 32'(lat), 5);
    check("ldw_n_en", 32'(nen), 1);
    do_req(1'b0, 1'b0, 1'b1, 16'h0011, 16'h0, rd, re, lat, enl, nen);
    check("ldb_s_data", 32'(rd), 32'hFFBE);
    do_req(1'b0, 1'b0, 1'b0, 16'h0011, 16'h0, rd, re, lat, enl, nen);
    check("ldb_u_data", 32'(rd), 32'h00BE);
    check("ldb_u_err", 32'(re), 0);

    // Back-to-back with ReqValid held, delay 0.
    mem_delay = 0;
    e0 = en_count; r0 = resp_count; na = 0;
    @(negedge Clock);
    ReqValid = 1'b1; ReqWrite = 1'b0; ReqWord = 1'b1; ReqSigned = 1'b0; ReqAddress = 16'h0010;
    for (int i = 0; i < 12; i++) begin
      rdy[i] = ReqReady;
      if (ReqReady && na < 4) begin acc[na] = cyc; na++; end
      @(negedge Clock);
    end
    ReqValid = 1'b0;
    repeat (3) @(negedge Clock);
    check("b2b_accepts", 32'(na), 3);
    check("b2b_gap1", 32'(acc[1] - acc[0]), 4);
    check("b2b_gap2", 32'(acc[2] - acc[1]), 4);
    check("b2b_rdy_lo", {29'h0, rdy[1], rdy[2], rdy[3]}, 0);
    check("b2b_rdy_hi", 32'(rdy[4]), 1);
    check("b2b_n_en", 32'(en_count - e0), 3);
    check("b2b_n_resp", 32'(resp_count - r0), 3);

    // Byte store writes only the addressed byte.
    do_req(1'b1, 1'b0, 1'b0, 16'h0021, 16'h77A5, rd, re, lat, enl, nen);
    check("stb_lat", 32'(lat), 3);
    check("stb_mem", {16'h0, mem[34], mem[33]}, 32'h000000A5);
    do_req(1'b0, 1'b0, 1'b1, 16'h0021, 16'h0, rd, re, lat, enl, nen);
    check("ldb_a5_s", 32'(rd), 32'hFFA5);
    do_req(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0, rd, re, lat, enl, nen);
    check("ldw_a500", 32'(rd), 32'hA500);

    // Watchdog: memory never answers.
    mem_stall = 1'b1;
    do_req(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0, rd, re, lat, enl, nen);
    check("to_lat", 32'(lat), 10);
    check("to_err", 32'(re), 1);
    check("to_data", 32'(rd), 0);
    check("to_n_en", 32'(nen), 1);
    r0 = resp_count; e0 = en_count;
    @(negedge Clock);
    force_rr = 1'b1;
    @(negedge Clock);
    force_rr = 1'b0;
    repeat (8) @(negedge Clock);
    check("late_rr_resp", 32'(resp_count - r0), 0);
    check("late_rr_en", 32'(en_count - e0), 0);
    check("late_rr_ready", 32'(ReqReady), 1);

    // Reset while in WAIT.
    @(negedge Clock);
    ReqValid = 1'b1; ReqWrite = 1'b0; ReqWord = 1'b1; ReqAddress = 16'h0010;
    n = 0;
    while (!ReqReady && n < 20) begin @(negedge Clock); n++; end
    @(negedge Clock);
    ReqValid = 1'b0;
    repeat (2) @(negedge Clock);
    check("wait_addr_held", 32'(MemAddress), 32'h0010);
    r0 = resp_count;
    Reset = 1'b1;
    @(negedge Clock);
    check_reset_outputs("midrst");
    Reset = 1'b0;
    mem_stall = 1'b0;
    repeat (12) @(negedge Clock);
    check("midrst_no_resp", 32'(resp_count - r0), 0);

    // Odd word address.
    mem_delay = 0;
    do_req(1'b0, 1'b1, 1'b0, 16'h0003, 16'h0, rd, re, lat, enl, nen);
`ifdef MISALIGN_TRAP_EN
    check("mis_err", 32'(re), 1);
    check("mis_data", 32'(rd), 0);
    check("mis_lat", 32'(lat), 1);
    check("mis_n_en", 32'(nen), 0);
`else
    check("odd_err", 32'(re), 0);
    check("odd_data", 32'(rd), 32'h1234);
    check("odd_lat", 32'(lat), 3);
    check("odd_n_en", 32'(nen), 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
